blake2b_iter: RTL and testbench

- Parametrised, iterative single-block BLAKE2b (unkeyed) hash engine with start/busy/done handshake.
- It is the next generation of the fixed blake2b hasher. It adds the following over that hasher:
  - selectable digest length
  - variable message length (0..128 bytes)
  - configurable G-function parallelism, trading area against latency
- It feeds the header-hashing datapath; one message in, one digest out per operation.

---
 rtl/blake2b_pkg.sv | 68 ++++++
 rtl/blake2b_g.sv | 32 +++
 rtl/blake2b_iter.sv | 194 +++++++++++++++++++
 tb/tb_blake2b_iter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2b_pkg.sv
// blake2b_pkg: shared constants, FSM state type and G-call index helpers
// for the iterative BLAKE2b engine.
package blake2b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
    } g_idx_t;

    localparam logic [63:0] IV [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // One row per word; nibble j holds the message index for position j.
    localparam logic [63:0] SIGMA [10] = '{
        64'hFEDCBA9876543210, 64'h357B20C16DF984AE,
        64'h491763EADF250C8B, 64'h8F04A562EBCD1397,
        64'hD386CB1EFA427509, 64'h91EF57D438B0A6C2,
        64'hB8293670A4DEF15C, 64'hA2684F05931CE7BD,
        64'h5A417D2C803B9EF6, 64'h0DC3E9BF5167482A
    };

    localparam int R1 = 32;
    localparam int R2 = 24;
    localparam int R3 = 16;
    localparam int R4 = 63;

    function automatic logic [3:0] sigma(input logic [3:0] row,
                                         input logic [3:0] pos);
        return SIGMA[row][{pos, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x,
                                         input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Calls 0..3 work on columns, 4..7 on diagonals.
    function automatic g_idx_t g_index(input logic [2:0] k);
        g_idx_t r;
        r = '0;
        case (k)
            3'd0: r = '{4'd0, 4'd4, 4'd8,  4'd12};
            3'd1: r = '{4'd1, 4'd5, 4'd9,  4'd13};
            3'd2: r = '{4'd2, 4'd6, 4'd10, 4'd14};
            3'd3: r = '{4'd3, 4'd7, 4'd11, 4'd15};
            3'd4: r = '{4'd0, 4'd5, 4'd10, 4'd15};
            3'd5: r = '{4'd1, 4'd6, 4'd11, 4'd12};
            3'd6: r = '{4'd2, 4'd7, 4'd8,  4'd13};
            3'd7: r = '{4'd3, 4'd4, 4'd9,  4'd14};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/blake2b_g.sv
// blake2b_g: one combinational BLAKE2b G mixing function on four
// state words and two message words.
module blake2b_g
    import blake2b_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] c,
    input  logic [63:0] d,
    input  logic [63:0] mx,
    input  logic [63:0] my,
    output logic [63:0] a_next,
    output logic [63:0] b_next,
    output logic [63:0] c_next,
    output logic [63:0] d_next
);

    logic [63:0] a1, b1, c1, d1;

    // Two half-mixes: first with mx and rotations 32/24, then my and 16/63.
    always_comb begin
        a1     = a + b + mx;
        d1     = rotr(d ^ a1, R1);
        c1     = c + d1;
        b1     = rotr(b ^ c1, R2);
        a_next = a1 + b1 + my;
        d_next = rotr(d1 ^ a_next, R3);
        c_next = c1 + d_next;
        b_next = rotr(b1 ^ c_next, R4);
    end

endmodule

// File: rtl/blake2b_iter.sv
// blake2b_iter: iterative single-block unkeyed BLAKE2b with selectable
// digest length and 1/2/4 G functions evaluated per cycle.
module blake2b_iter
    import blake2b_pkg::*;
#(
    parameter int OUT_BYTES   = 32,
    parameter int G_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1023:0]          msg,
    input  logic [7:0]             msg_len,
    output logic                   busy,
    output logic                   done,
    output logic [OUT_BYTES*8-1:0] hash
);

    localparam int          STEPS = 96 / G_PER_CYCLE;
    localparam logic [6:0]  LAST  = 7'(STEPS - 1);
    localparam logic [63:0] P0    = 64'h0101_0000 ^ 64'(OUT_BYTES);

    if (!(G_PER_CYCLE == 1 || G_PER_CYCLE == 2 || G_PER_CYCLE == 4))
    begin : g_bad_par
        $error("G_PER_CYCLE must be 1, 2 or 4");
    end

    state_t state, state_nxt;

    logic [6:0]    step;
    logic [63:0]   v     [16];
    logic [63:0]   v_nxt [16];
    logic [63:0]   h     [8];
    logic [63:0]   h_fin [8];
    logic [63:0]   mw    [16];
    logic [1023:0] m_reg;
    logic [1023:0] m_mask;
    logic [7:0]    len_reg;
    logic [7:0]    len_c;
    logic          accept;
    logic [6:0]    base;
    logic [3:0]    round;
    logic [3:0]    row;

    logic [OUT_BYTES*8-1:0] hash_nxt;

    logic [3:0]  ia [G_PER_CYCLE];
    logic [3:0]  ib [G_PER_CYCLE];
    logic [3:0]  ic [G_PER_CYCLE];
    logic [3:0]  id [G_PER_CYCLE];
    logic [63:0] oa [G_PER_CYCLE];
    logic [63:0] ob [G_PER_CYCLE];
    logic [63:0] oc [G_PER_CYCLE];
    logic [63:0] od [G_PER_CYCLE];

    // The done cycle still counts as busy-side: a start there is dropped.
    assign accept = (state == IDLE) && start && !done;

    // Clamp the length and zero every byte past it before capture.
    always_comb begin
        len_c = (msg_len > 8'd128) ? 8'd128 : msg_len;
        for (int i = 0; i < 128; i++) begin
            m_mask[8*i +: 8] = (8'(i) < len_c) ? msg[8*i +: 8] : 8'h00;
        end
    end

    // Captured block viewed as sixteen little-endian words.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            mw[i] = m_reg[64*i +: 64];
        end
    end

    // Position of this step inside the 96 G calls.
    assign base  = step * 7'(G_PER_CYCLE);
    assign round = base[6:3];
    assign row   = (round >= 4'd10) ? round - 4'd10 : round;

    for (genvar j = 0; j < G_PER_CYCLE; j++) begin : g_lane
        logic [2:0] k;
        g_idx_t     gi;

        assign k     = base[2:0] + 3'(j);
        assign gi    = g_index(k);
        assign ia[j] = gi.a;
        assign ib[j] = gi.b;
        assign ic[j] = gi.c;
        assign id[j] = gi.d;

        blake2b_g u_g (
            .a      (v[gi.a]),
            .b      (v[gi.b]),
            .c      (v[gi.c]),
            .d      (v[gi.d]),
            .mx     (mw[sigma(row, {k, 1'b0})]),
            .my     (mw[sigma(row, {k, 1'b1})]),
            .a_next (oa[j]),
            .b_next (ob[j]),
            .c_next (oc[j]),
            .d_next (od[j])
        );
    end

    // Lanes in one step touch disjoint words, so write-back never collides.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            v_nxt[i] = v[i];
        end
        for (int j = 0; j < G_PER_CYCLE; j++) begin
            v_nxt[ia[j]] = oa[j];
            v_nxt[ib[j]] = ob[j];
            v_nxt[ic[j]] = oc[j];
            v_nxt[id[j]] = od[j];
        end
    end

    // Feed-forward and digest packing, byte 0 at the MSBs.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            h_fin[i] = h[i] ^ v[i] ^ v[i+8];
        end
        hash_nxt = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            hash_nxt[(OUT_BYTES-1-i)*8 +: 8] = h_fin[i/8][8*(i%8) +: 8];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = INIT;
            INIT:    state_nxt = ROUND;
            ROUND:   if (step == LAST) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, initialise, iterate, finalise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            hash    <= '0;
            step    <= '0;
            m_reg   <= '0;
            len_reg <= '0;
            for (int i = 0; i < 16; i++) v[i] <= '0;
            for (int i = 0; i < 8; i++)  h[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        m_reg   <= m_mask;
                        len_reg <= len_c;
                        busy    <= 1'b1;
                    end
                end
                INIT: begin
                    for (int i = 0; i < 8; i++) begin
                        h[i]   <= IV[i];
                        v[i]   <= IV[i];
                        v[i+8] <= IV[i];
                    end
                    h[0]  <= IV[0] ^ P0;
                    v[0]  <= IV[0] ^ P0;
                    v[12] <= IV[4] ^ {56'd0, len_reg};
                    v[14] <= ~IV[6];
                    step  <= '0;
                end
                ROUND: begin
                    for (int i = 0; i < 16; i++) v[i] <= v_nxt[i];
                    step <= step + 7'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h[i] <= h_fin[i];
                    hash <= hash_nxt;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2b_iter.sv
// tb_blake2b_iter: directed vectors and handshake sequences for
// blake2b_iter at several digest lengths and G parallelisms.
module tb_blake2b_iter;

    logic          clk = 1'b0;
    logic          rst_n [4];
    logic          start [4];
    logic          busy  [4];
    logic          done  [4];
    logic [1023:0] msg;
    logic [7:0]    msg_len;
    logic [255:0]  hash0;
    logic [511:0]  hash1, hash2, hash3;

    int n_chk = 0;
    int n_fail = 0;
    int dcnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    blake2b_iter #(.OUT_BYTES(32), .G_PER_CYCLE(4)) u_32g4 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .msg(msg),
        .msg_len(msg_len), .busy(busy[0]), .done(done[0]), .hash(hash0));
    blake2b_iter #(.OUT_BYTES(64), .G_PER_CYCLE(4)) u_64g4 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .msg(msg),
        .msg_len(msg_len), .busy(busy[1]), .done(done[1]), .hash(hash1));
    blake2b_iter #(.OUT_BYTES(64), .G_PER_CYCLE(2)) u_64g2 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .msg(msg),
        .msg_len(msg_len), .busy(busy[2]), .done(done[2]), .hash(hash2));
    blake2b_iter #(.OUT_BYTES(64), .G_PER_CYCLE(1)) u_64g1 (
        .clk(clk), .rst_n(rst_n[3]), .start(start[3]), .msg(msg),
        .msg_len(msg_len), .busy(busy[3]), .done(done[3]), .hash(hash3));

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (done[k]) dcnt[k]++;
    end

    // Reference constants, written in the published row order.
    logic [63:0] tiv [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    int ts [10][16] = '{
        '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15},
        '{14,10,4,8,9,15,13,6,1,12,0,2,11,7,5,3},
        '{11,8,12,0,5,2,15,13,10,14,3,6,7,1,9,4},
        '{7,9,3,1,13,12,11,14,2,6,5,10,4,0,15,8},
        '{9,0,5,7,2,4,10,15,14,1,11,12,6,8,3,13},
        '{2,12,6,10,0,11,8,3,4,13,7,5,15,14,1,9},
        '{12,5,1,15,14,13,4,10,0,7,6,3,9,2,8,11},
        '{13,11,7,14,12,1,3,9,5,0,15,4,8,6,2,10},
        '{6,15,14,9,11,3,0,8,12,2,13,7,1,4,10,5},
        '{10,2,8,4,7,6,1,5,15,11,9,14,3,12,13,0}};
    int gat [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int gbt [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int gct [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int gdt [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Software BLAKE2b of one final block, digest byte 0 at the MSBs.
    function automatic logic [511:0] model(input logic [1023:0] m,
                                           input int len, input int ob);
        logic [63:0]   hh [8];
        logic [63:0]   vv [16];
        logic [63:0]   mm [16];
        logic [1023:0] mb;
        logic [511:0]  r;
        int n, a, b, c, d, s;
        n  = (len > 128) ? 128 : len;
        mb = '0;
        for (int i = 0; i < n; i++) mb[8*i +: 8] = m[8*i +: 8];
        for (int i = 0; i < 16; i++) mm[i] = mb[64*i +: 64];
        for (int i = 0; i < 8; i++) begin
            hh[i] = tiv[i]; vv[i] = tiv[i]; vv[i+8] = tiv[i];
        end
        hh[0] = hh[0] ^ 64'h0101_0000 ^ 64'(ob);
        vv[0] = hh[0];
        vv[12] = vv[12] ^ 64'(n);
        vv[14] = ~vv[14];
        for (int rd = 0; rd < 12; rd++) begin
            s = rd % 10;
            for (int k = 0; k < 8; k++) begin
                a = gat[k]; b = gbt[k]; c = gct[k]; d = gdt[k];
                vv[a] = vv[a] + vv[b] + mm[ts[s][2*k]];
                vv[d] = rr(vv[d] ^ vv[a], 32);
                vv[c] = vv[c] + vv[d];
                vv[b] = rr(vv[b] ^ vv[c], 24);
                vv[a] = vv[a] + vv[b] + mm[ts[s][2*k+1]];
                vv[d] = rr(vv[d] ^ vv[a], 16);
                vv[c] = vv[c] + vv[d];
                vv[b] = rr(vv[b] ^ vv[c], 63);
            end
        end
        for (int i = 0; i < 8; i++) hh[i] = hh[i] ^ vv[i] ^ vv[i+8];
        r = '0;
        for (int i = 0; i < ob; i++) r[(ob-1-i)*8 +: 8] = hh[i/8][8*(i%8) +: 8];
        return r;
    endfunction

    function automatic logic [511:0] get_hash(input int k);
        case (k)
            0:       return {256'd0, hash0};
            1:       return hash1;
            2:       return hash2;
            default: return hash3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Run one hash on instance k and check latency, busy, digest, pulse.
    task automatic run_op(input int k, input logic [1023:0] m,
                          input logic [7:0] len, input logic [511:0] exp,
                          input int lat, input string nm);
        int  cnt;
        bit  busy_ok;
        @(negedge clk);
        msg = m; msg_len = len; start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        msg = {32{$urandom}}; msg_len = 8'($urandom);
        busy_ok = busy[k];
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (done[k]) break;
            if (!busy[k]) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, 512'(cnt), 512'(lat));
        chk({nm, "_busy"}, 512'(busy_ok), 512'd1);
        chk({nm, "_hash"}, get_hash(k), exp);
        chk({nm, "_busy_low"}, 512'(busy[k]), 512'd0);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, 512'(done[k]), 512'd0);
        chk({nm, "_hash_hold"}, get_hash(k), exp);
    endtask

    typedef struct {
        int            inst;
        logic [1023:0] m;
        logic [7:0]    len;
        logic [511:0]  exp;
        int            lat;
    } vec_t;

    localparam logic [511:0] ABC64 = 512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923;
    localparam logic [511:0] EMP64 = 512'h786a02f742015903c6c6fd852552d272912f4740e15847618a86e217f71f5419d25e1031afee585313896444934eb04b903a685b1448b755d56f701afe9be2ce;
    localparam logic [511:0] ABC32 = 512'hbddd813c634239723171ef3fee98579b94964e3bb1cb3e427262c8c068d52319;

    initial begin
        vec_t          tbl [8];
        logic [1023:0] abc, ones, rnd;
        logic [511:0]  e2;
        int            cnt, d0;

        abc  = 1024'h636261;
        ones = '1;
        for (int i = 0; i < 32; i++) rnd[32*i +: 32] = $urandom;

        tbl[0] = '{0, abc,  8'd3,   ABC32, 26};
        tbl[1] = '{1, ones, 8'd0,   EMP64, 26};
        tbl[2] = '{1, abc,  8'd3,   ABC64, 26};
        tbl[3] = '{2, abc,  8'd3,   ABC64, 50};
        tbl[4] = '{3, abc,  8'd3,   ABC64, 98};
        tbl[5] = '{1, rnd,  8'd200, model(rnd, 128, 64), 26};
        tbl[6] = '{2, rnd,  8'd77,  model(rnd, 77, 64), 50};
        tbl[7] = '{0, rnd,  8'd128, model(rnd, 128, 32), 26};

        msg = '0; msg_len = '0;
        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_busy%0d", k), 512'(busy[k]), 512'd0);
            chk($sformatf("rst_done%0d", k), 512'(done[k]), 512'd0);
            chk($sformatf("rst_hash%0d", k), get_hash(k), 512'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].inst, tbl[i].m, tbl[i].len, tbl[i].exp,
                   tbl[i].lat, $sformatf("vec%0d", i));
        end

        // Starts mid-hash and on the done cycle are dropped.
        d0 = dcnt[0];
        @(negedge clk);
        msg = abc; msg_len = 8'd3; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; msg = ones; msg_len = 8'd0;
        repeat (10) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        cnt = 11;
        while (cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (done[0]) break;
        end
        chk("b2b_latency", 512'(cnt), 512'd26);
        chk("b2b_hash", get_hash(0), ABC32);
        start[0] = 1'b1;
        @(posedge clk); #1;
        chk("b2b_done_cycle_ignored", 512'(busy[0]), 512'd0);
        @(posedge clk); #1;
        start[0] = 1'b0;
        chk("b2b_next_accepted", 512'(busy[0]), 512'd1);
        chk("b2b_hash_kept", get_hash(0), ABC32);
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (done[0]) break;
        end
        e2 = model(ones, 0, 32);
        chk("b2b2_latency", 512'(cnt), 512'd26);
        chk("b2b2_hash", get_hash(0), e2);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_done_count", 512'(dcnt[0] - d0), 512'd2);

        // Asynchronous reset at step 10 aborts without a done pulse.
        @(negedge clk);
        msg = abc; msg_len = 8'd3; start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        chk("abort_busy_before", 512'(busy[1]), 512'd1);
        d0 = dcnt[1];
        rst_n[1] = 1'b0;
        #1;
        chk("abort_busy", 512'(busy[1]), 512'd0);
        chk("abort_done", 512'(done[1]), 512'd0);
        chk("abort_hash", get_hash(1), 512'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", 512'(dcnt[1] - d0), 512'd0);
        run_op(1, abc, 8'd3, ABC64, 26, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
